// File: rtl/mem_port_arbiter.sv
// Single-port memory bus arbiter between the IF (fetch) and MEM (load/store) stages.
// One transaction at a time, round-robin on contention, done pulses, stall and watchdog abort.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              stall_pipe,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic GRANT_IF  = 1'b0;
  localparam logic GRANT_MEM = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_IF  = 2'd1,
    ST_WAIT_MEM = 2'd2,
    ST_RESP     = 2'd3
  } state_e;

  state_e            state_q;
  logic              last_grant_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              grant_mem_d;
  logic              expire_d;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic              bus_err_q;
  logic              if_done_q;
  logic              mem_done_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;

  // Grant choice, saturating wait counter and watchdog expiry.
  always_comb begin
    grant_mem_d = 1'b0;
    cnt_d       = cnt_q;
    expire_d    = 1'b0;
    if (mem_req && (!if_req || (last_grant_q == GRANT_IF))) begin
      grant_mem_d = 1'b1;
    end else begin
      grant_mem_d = 1'b0;
    end
    if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (TIMEOUT == 0) begin
      expire_d = 1'b0;
    end else begin
      expire_d = (cnt_q == CNT_W'(TIMEOUT - 1));
    end
  end

  // Transaction sequencer; ack wins over a same-cycle watchdog expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_IF;
      cnt_q        <= CNT_W'(0);
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= {ADDR_W{1'b0}};
      bus_wdata_q  <= {DATA_W{1'b0}};
      bus_err_q    <= 1'b0;
      if_done_q    <= 1'b0;
      mem_done_q   <= 1'b0;
      if_rdata_q   <= {DATA_W{1'b0}};
      mem_rdata_q  <= {DATA_W{1'b0}};
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mem_req || if_req) begin
            bus_req_q <= 1'b1;
            cnt_q     <= CNT_W'(0);
            if (grant_mem_d) begin
              state_q     <= ST_WAIT_MEM;
              bus_we_q    <= mem_we;
              bus_addr_q  <= mem_addr;
              bus_wdata_q <= mem_wdata;
            end else begin
              state_q     <= ST_WAIT_IF;
              bus_we_q    <= 1'b0;
              bus_addr_q  <= if_addr;
              bus_wdata_q <= {DATA_W{1'b0}};
            end
          end
        end
        ST_WAIT_IF, ST_WAIT_MEM: begin
          if (bus_ack || expire_d) begin
            bus_req_q <= 1'b0;
            state_q   <= ST_RESP;
            if (!bus_ack) begin
              bus_err_q <= 1'b1;
            end
            // Aborted reads deliver zero; stores never touch mem_rdata.
            if (state_q == ST_WAIT_MEM) begin
              mem_done_q   <= 1'b1;
              last_grant_q <= GRANT_MEM;
              if (!bus_we_q) begin
                mem_rdata_q <= bus_ack ? bus_rdata : {DATA_W{1'b0}};
              end
            end else begin
              if_done_q    <= 1'b1;
              last_grant_q <= GRANT_IF;
              if_rdata_q   <= bus_ack ? bus_rdata : {DATA_W{1'b0}};
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_err    = bus_err_q;
  assign if_done    = if_done_q;
  assign mem_done   = mem_done_q;
  assign if_rdata   = if_rdata_q;
  assign mem_rdata  = mem_rdata_q;
  assign stall_pipe = (if_req & ~if_done_q) | (mem_req & ~mem_done_q);

endmodule
